// File: rtl/grid_pkg.sv
// Shared types and width helpers for the grid tile links and buffering stages.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package grid_pkg;

  // Lane width in bits: elements per sample times bits per element.
  function automatic int lane_w(input int data_size, input int sample_size);
    return data_size * sample_size;
  endfunction

  // Occupancy counter width; it must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // One direction of a valid/rec handshake, as used on the tile links.
  typedef struct packed {
    logic val;
    logic rec;
  } hs_t;

endpackage

// File: rtl/grid_lane_fifo_if.sv
// Multi-lane sample bus with per-lane valid/rec on the upstream and downstream side.
// Latency: n/a (wiring only).
// Backpressure: in_rec from the buffer to upstream, out_rec from downstream to the buffer.
// Ports: in_data/in_val/in_rec (upstream side), out_data/out_val/out_rec (downstream side);
//        lane i occupies bits [i*W +: W] of each data vector.
interface grid_lane_fifo_if #(
  parameter int NUM_LANES = 2,
  parameter int W         = 16
);
  logic [NUM_LANES*W-1:0] in_data;
  logic [NUM_LANES-1:0]   in_val;
  logic [NUM_LANES-1:0]   in_rec;
  logic [NUM_LANES*W-1:0] out_data;
  logic [NUM_LANES-1:0]   out_val;
  logic [NUM_LANES-1:0]   out_rec;

  // master: the environment that feeds samples in and accepts them out.
  modport master (
    output in_data, in_val, out_rec,
    input  in_rec, out_data, out_val
  );

  // slave: the buffering stage itself.
  modport slave (
    input  in_data, in_val, out_rec,
    output in_rec, out_data, out_val
  );
endinterface

// File: rtl/lane_fifo.sv
// Single-lane FIFO: storage, wrap-around pointers, occupancy count and sticky drop flag.
// Latency: written entry appears at head one cycle after push; head is a combinational read.
// Backpressure: none internally; caller must gate push with !full and pop with !empty.
// Ports: clk, rst (async active-low), push, pop, flush, ovf (overflow attempt), in_dat,
//        head, full, empty, count, drop_err.
module lane_fifo
  import grid_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic                     ovf,
  input  logic [W-1:0]             in_dat,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     drop_err
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // DEPTH need not be a power of two, so wrap explicitly at DEPTH-1.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage is cleared only by reset; flush just rewinds the pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= in_dat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (ovf) drop_err <= 1'b1;
    end
  end

endmodule

// File: rtl/grid_lane_fifo.sv
// Multi-lane inter-tile buffer with independent or lockstep release, flush and drop flags.
// Latency: one cycle from accepted push to out_val; no combinational bypass.
// Backpressure: in_rec drops when a lane is full, disabled or flushing; never depends on out_rec.
// Ports: clk, rst (async active-low), enable, flush, lockstep, lane_if (slave: in_/out_
//        data/val/rec per lane), count (CW bits per lane), drop_err (sticky per lane).
module grid_lane_fifo
  import grid_pkg::*;
#(
  parameter int DATA_SIZE   = 4,
  parameter int SAMPLE_SIZE = 4,
  parameter int NUM_LANES   = 2,
  parameter int DEPTH       = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic                                flush,
  input  logic                                lockstep,
  grid_lane_fifo_if.slave                     lane_if,
  output logic [NUM_LANES*cnt_w(DEPTH)-1:0]   count,
  output logic [NUM_LANES-1:0]                drop_err
);

  localparam int W  = lane_w(DATA_SIZE, SAMPLE_SIZE);
  localparam int CW = cnt_w(DEPTH);

  logic [NUM_LANES-1:0]   full;
  logic [NUM_LANES-1:0]   empty;
  logic [NUM_LANES-1:0]   push;
  logic [NUM_LANES-1:0]   pop;
  logic [NUM_LANES-1:0]   ovf;
  logic [NUM_LANES*W-1:0] head_dat;
  hs_t  [NUM_LANES-1:0]   up_hs;
  hs_t  [NUM_LANES-1:0]   dn_hs;
  logic                   all_ne;
  logic                   all_rec;
  logic                   run;

  // run folds in rst so handshakes read 0 while reset is held, independent of enable.
  assign run     = rst & enable & ~flush;
  assign all_ne  = ~|empty;
  assign all_rec = &lane_if.out_rec;

  always_comb begin
    up_hs = '0;
    dn_hs = '0;
    push  = '0;
    pop   = '0;
    ovf   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      up_hs[i].val = lane_if.in_val[i];
      up_hs[i].rec = run & ~full[i];
      dn_hs[i].rec = lane_if.out_rec[i];
      // Lockstep presents every lane only when all of them hold data.
      dn_hs[i].val = lockstep ? (run & all_ne) : (run & ~empty[i]);
      push[i] = up_hs[i].val & up_hs[i].rec;
      // In lockstep a lane pops only together with all others.
      pop[i]  = lockstep ? (dn_hs[i].val & all_rec) : (dn_hs[i].val & dn_hs[i].rec);
      ovf[i]  = run & up_hs[i].val & full[i];
    end
  end

  always_comb begin
    lane_if.in_rec  = '0;
    lane_if.out_val = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_if.in_rec[i]  = up_hs[i].rec;
      lane_if.out_val[i] = dn_hs[i].val;
    end
  end

  assign lane_if.out_data = head_dat;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .push     (push[g]),
      .pop      (pop[g]),
      .flush    (flush),
      .ovf      (ovf[g]),
      .in_dat   (lane_if.in_data[g*W +: W]),
      .head     (head_dat[g*W +: W]),
      .full     (full[g]),
      .empty    (empty[g]),
      .count    (count[g*CW +: CW]),
      .drop_err (drop_err[g])
    );
  end

endmodule

// File: tb/tb_grid_lane_fifo.sv
// Scoreboard bench for grid_lane_fifo: directed stimulus queues expected words per lane,
// a negedge monitor pops and compares whenever a lane actually releases a word.
module tb_grid_lane_fifo;
  localparam int NL = 2;
  localparam int W  = 16;
  localparam int CW = 3;

  logic clk;
  logic rst;
  logic enable;
  logic flush;
  logic lockstep;
  logic [NL*CW-1:0] count;
  logic [NL-1:0]    drop_err;

  grid_lane_fifo_if #(.NUM_LANES(NL), .W(W)) lf ();

  grid_lane_fifo #(
    .DATA_SIZE   (4),
    .SAMPLE_SIZE (4),
    .NUM_LANES   (NL),
    .DEPTH       (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .flush    (flush),
    .lockstep (lockstep),
    .lane_if  (lf.slave),
    .count    (count),
    .drop_err (drop_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q [NL][$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [W-1:0] d);
    lf.in_data[lane*W +: W] = d;
  endtask

  // Monitor: a word leaves a lane when it is valid, its rec is high and, in
  // lockstep, every rec is high.
  always @(negedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (rst && lf.out_val[i] && lf.out_rec[i] && (!lockstep || (&lf.out_rec))) begin
        if (exp_q[i].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected lane%0d: got %h, expected no word", i,
                   lf.out_data[i*W +: W]);
        end else begin
          logic [W-1:0] e;
          e = exp_q[i].pop_front();
          check($sformatf("pop_lane%0d", i), 32'(lf.out_data[i*W +: W]), 32'(e));
        end
      end
    end
  end

  initial begin
    rst        = 1'b0;
    enable     = 1'b0;
    flush      = 1'b0;
    lockstep   = 1'b0;
    lf.in_data = '0;
    lf.in_val  = '0;
    lf.out_rec = '0;

    // Reset state
    #3;
    check("rst_count",    32'(count),       32'd0);
    check("rst_out_val",  32'(lf.out_val),  32'd0);
    check("rst_in_rec",   32'(lf.in_rec),   32'd0);
    check("rst_drop_err", 32'(drop_err),    32'd0);
    check("rst_out_data", 32'(lf.out_data), 32'd0);
    tick();
    tick();
    rst    = 1'b1;
    enable = 1'b1;

    // Single push, one-cycle latency
    tick();
    set_lane(0, 16'hA5A5);
    lf.in_val = 2'b01;
    exp_q[0].push_back(16'hA5A5);
    #1;
    check("t0_out_val", 32'(lf.out_val), 32'd0);
    check("t0_in_rec",  32'(lf.in_rec),  32'(2'b11));
    tick();
    lf.in_val = 2'b00;
    #1;
    check("t1_out_val",  32'(lf.out_val),       32'(2'b01));
    check("t1_out_data", 32'(lf.out_data[15:0]), 32'h0000A5A5);
    check("t1_count",    32'(count),            32'd1);
    lf.out_rec = 2'b01;
    tick();
    lf.out_rec = 2'b00;
    check("t1_drained", 32'(count), 32'd0);

    // Fill to full, overflow, drain in order
    for (int k = 1; k <= 4; k++) begin
      set_lane(0, 16'(k));
      lf.in_val = 2'b01;
      exp_q[0].push_back(16'(k));
      tick();
    end
    set_lane(0, 16'h0005);
    #1;
    check("full_in_rec", 32'(lf.in_rec[0]), 32'd0);
    check("full_count",  32'(count),        32'd4);
    tick();
    lf.in_val = 2'b00;
    #1;
    check("ovf_drop_err", 32'(drop_err), 32'(2'b01));
    lf.out_rec = 2'b01;
    repeat (4) tick();
    lf.out_rec = 2'b00;
    check("fill_drained",   32'(count),             32'd0);
    check("fill_q_empty",   32'(exp_q[0].size()),   32'd0);
    check("drop_sticky",    32'(drop_err),          32'(2'b01));

    // Streaming at one word per cycle, pointers wrap
    lf.out_rec = 2'b01;
    for (int v = 0; v < 10; v++) begin
      set_lane(0, 16'(v));
      lf.in_val = 2'b01;
      exp_q[0].push_back(16'(v));
      tick();
      check($sformatf("stream_count_%0d", v), 32'(count), 32'd1);
    end
    lf.in_val = 2'b00;
    tick();
    lf.out_rec = 2'b00;
    check("stream_drained", 32'(count), 32'd0);

    // Lockstep release
    lockstep = 1'b1;
    set_lane(0, 16'h0011);
    lf.in_val = 2'b01;
    exp_q[0].push_back(16'h0011);
    tick();
    lf.in_val  = 2'b00;
    lf.out_rec = 2'b11;
    #1;
    check("ls_one_empty_val", 32'(lf.out_val), 32'd0);
    tick();
    check("ls_no_pop_count", 32'(count), 32'(6'b000_001));
    set_lane(1, 16'h0022);
    lf.in_val = 2'b10;
    exp_q[1].push_back(16'h0022);
    tick();
    lf.in_val  = 2'b00;
    lf.out_rec = 2'b01;
    #1;
    check("ls_both_val", 32'(lf.out_val), 32'(2'b11));
    tick();
    check("ls_partial_rec_count", 32'(count), 32'(6'b001_001));
    lf.out_rec = 2'b11;
    tick();
    check("ls_pop_count", 32'(count), 32'd0);
    lockstep   = 1'b0;
    lf.out_rec = 2'b00;

    // Flush clears counts and drop flags
    set_lane(0, 16'h0031); set_lane(1, 16'h0041); lf.in_val = 2'b11;
    tick();
    set_lane(0, 16'h0032); set_lane(1, 16'h0042); lf.in_val = 2'b11;
    tick();
    set_lane(0, 16'h0033); lf.in_val = 2'b01;
    tick();
    lf.in_val = 2'b00;
    check("pre_flush_count", 32'(count),    32'(6'b010_011));
    check("pre_flush_drop",  32'(drop_err), 32'(2'b01));
    flush     = 1'b1;
    lf.in_val = 2'b11;
    #1;
    check("flush_in_rec",  32'(lf.in_rec),  32'd0);
    check("flush_out_val", 32'(lf.out_val), 32'd0);
    tick();
    flush     = 1'b0;
    lf.in_val = 2'b00;
    #1;
    check("post_flush_count",   32'(count),      32'd0);
    check("post_flush_drop",    32'(drop_err),   32'd0);
    check("post_flush_out_val", 32'(lf.out_val), 32'd0);
    set_lane(0, 16'h0077);
    lf.in_val = 2'b01;
    exp_q[0].push_back(16'h0077);
    tick();
    lf.in_val = 2'b00;
    #1;
    check("after_flush_count", 32'(count),      32'd1);
    check("after_flush_val",   32'(lf.out_val), 32'(2'b01));
    lf.out_rec = 2'b01;
    tick();
    lf.out_rec = 2'b00;

    // Enable gating, then asynchronous reset mid-cycle
    set_lane(0, 16'h0061); lf.in_val = 2'b01;
    tick();
    set_lane(0, 16'h0062);
    tick();
    lf.in_val = 2'b00;
    check("pre_dis_count", 32'(count), 32'd2);
    enable     = 1'b0;
    lf.in_val  = 2'b01;
    lf.out_rec = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("dis_in_rec_%0d", c),  32'(lf.in_rec),  32'd0);
      check($sformatf("dis_out_val_%0d", c), 32'(lf.out_val), 32'd0);
      check($sformatf("dis_count_%0d", c),   32'(count),      32'd2);
      tick();
    end
    enable     = 1'b1;
    lf.in_val  = 2'b00;
    lf.out_rec = 2'b00;
    #1;
    check("re_en_out_val", 32'(lf.out_val), 32'(2'b01));
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_count",   32'(count),      32'd0);
    check("async_rst_out_val", 32'(lf.out_val), 32'd0);
    tick();
    tick();
    check("end_q0_empty", 32'(exp_q[0].size()), 32'd0);
    check("end_q1_empty", 32'(exp_q[1].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_lane_fifo.md
Name: grid_lane_fifo

Overview:
- Parametrised multi-lane buffering stage placed between grid tiles, for example between 2x2 tiles inside a 4x4 or larger grid.
- Carries NUM_LANES independent sample lanes, each with a DEPTH-entry FIFO and valid/rec handshakes on both sides.
- Adds features the plain inter-tile links do not have: configurable depth, a lockstep mode that releases all lanes together, a synchronous flush, per-lane occupancy counts and sticky drop flags.

Parameters:
- DATA_SIZE, 4, bits per sample element.
- SAMPLE_SIZE, 4, elements per sample word. Lane width W = DATA_SIZE*SAMPLE_SIZE.
- NUM_LANES, 2, number of independent lanes (>=1).
- DEPTH, 4, entries per lane FIFO (>=2; need not be a power of 2).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  global run gate.
- flush  in  1  synchronous clear of all lanes.
- lockstep  in  1  1 = all-lanes-aligned release; 0 = independent lanes.
- in_data  in  NUM_LANES*W  lane i at [i*W +: W].
- in_val  in  NUM_LANES  upstream valid per lane.
- in_rec  out  NUM_LANES  ready to upstream per lane.
- out_data  out  NUM_LANES*W  head entry of each lane.
- out_val  out  NUM_LANES  valid to downstream per lane.
- out_rec  in  NUM_LANES  downstream ready per lane.
- count  out  NUM_LANES*CW  occupancy per lane, CW = $clog2(DEPTH+1).
- drop_err  out  NUM_LANES  sticky: push attempted while lane full.

Behaviour:
- Reset (rst=0, async): all pointers, counts and drop_err = 0; out_val = 0; in_rec = 0; out_data = 0 (storage cleared).
- in_rec[i] = enable & !full[i] & !flush. Combinational from state only; never depends on out_rec.
- Push[i] = in_val[i] & in_rec[i]. Writes mem[wr_ptr] and advances wr_ptr.
- Independent mode:
  - out_val[i] = enable & !empty[i] & !flush.
  - Pop[i] = out_val[i] & out_rec[i].
- Lockstep mode:
  - all_ne = every lane non-empty.
  - out_val[i] = enable & all_ne & !flush for every i.
  - Pop of all lanes occurs only when all_ne and every out_rec is high. Otherwise no lane pops, even if some lanes have their rec asserted.
- out_data[i] = mem_i[rd_ptr_i], combinational read. Held stable while out_val[i]=1 and no pop occurs.
- Latency: a push at cycle t makes out_val visible at t+1 at the earliest. There is no combinational bypass.
- Pointer wrap: wr_ptr and rd_ptr go from DEPTH-1 to 0.
- Count update:
  - push and no pop: count+1.
  - pop and no push: count-1.
  - push and pop in the same cycle (allowed when 0<count<DEPTH): count unchanged.
- Full (count==DEPTH): in_rec=0, so no same-cycle push-while-pop on a full lane.
- Empty (count==0): out_val=0. A pop request is ignored.
- Overflow: in_val[i]=1 while full[i] and enable=1 and flush=0. The data is dropped, drop_err[i] is set and stays set until flush or reset.
- Flush=1 for one cycle:
  - Next cycle: all pointers, counts and drop_err = 0.
  - During the flush cycle: in_rec=0, out_val=0, no push or pop.
  - Flush has priority over everything except reset.
- enable=0: in_rec=0, out_val=0, all state held; flush still acts.
- Mode switch: lockstep may change at any cycle and takes effect combinationally in that cycle. Contents are preserved.
- Reset asserted mid-operation: immediate clear; all in-flight data is lost.

Decomposition:
- grid_pkg holds:
  - function lane_w(DATA_SIZE, SAMPLE_SIZE).
  - function cnt_w(DEPTH) = $clog2(DEPTH+1).
  - typedef for the handshake pair {val, rec}, shared with the tile interfaces.
- One sub-module, lane_fifo:
  - Single-lane storage, pointers, count and drop flag.
  - Inputs: push, pop, flush.
  - Outputs: full, empty, head.
- The top generates NUM_LANES lane_fifo instances and holds the lockstep pop/valid logic.

Test Plan:
- Reset, then push 0xA5A5 into lane0 at t0 (independent mode) -> out_val[0]=0 at t0, =1 at t1 with out_data[0]=0xA5A5; count[0]=1; lane1 out_val stays 0.
- Fill lane0 with 4 words 0x1,0x2,0x3,0x4 while out_rec=0 -> count[0]=4, in_rec[0]=0. A fifth push of 0x5 sets drop_err[0]=1. Draining then yields 0x1..0x4 in order; 0x5 never appears.
- Continuous push and pop at 1 word/cycle for 10 cycles with values 0..9 -> count stays 1; pointers wrap past DEPTH-1; output sequence is 0..9 in order.
- Lockstep=1, lane0 holds 0x11, lane1 empty, out_rec=2'b11 -> out_val=2'b00, no pop. Push 0x22 to lane1 -> next cycle out_val=2'b11. With out_rec=2'b01 no pop occurs; with 2'b11 both lanes pop and counts go to 0.
- Lanes holding 3 and 2 entries with drop_err[0]=1, assert flush for one cycle -> next cycle counts=0, drop_err=0, out_val=0. A push on the following cycle is accepted normally.
- Lane0 holding 2 entries, drop enable to 0 for 3 cycles with in_val=1 and out_rec=1 -> in_rec=0, out_val=0, count unchanged at 2. Assert rst=0 mid-cycle -> count and out_val go to 0 immediately, without waiting for a clock edge.
